// File: rtl/core_data_obi_router_if.sv
// OBI-style data bus bundle; NS is the number of request/response slots carried side by side.
interface core_data_obi_router_if #(
   parameter int unsigned NS     = 1,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = 1
);
   logic [NS-1:0]        req;
   logic [NS-1:0]        gnt;
   logic [ADDR_W-1:0]    addr;
   logic                 we;
   logic [DATA_W/8-1:0]  be;
   logic [DATA_W-1:0]    wdata;
   logic [ID_W-1:0]      aid;
   logic [NS-1:0]        rvalid;
   logic [NS*DATA_W-1:0] rdata;
   logic [NS*ID_W-1:0]   rid;
   logic [NS-1:0]        err;

   modport master (
      output req, addr, we, be, wdata, aid,
      input  gnt, rvalid, rdata, rid, err
   );

   modport slave (
      input  req, addr, we, be, wdata, aid,
      output gnt, rvalid, rdata, rid, err
   );
endinterface

// File: rtl/core_data_obi_router.sv
// Routes the core data OBI manager to L1 (slot 0), L2 (slot 1) or an internal error subordinate,
// holding any target switch until every outstanding response has returned.
module core_data_obi_router #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       ID_W       = 1,
   parameter int unsigned       N_MAX_TRAN = 1,
   parameter logic [ADDR_W-1:0] L1_START   = ADDR_W'(32'h1000_0000),
   parameter logic [ADDR_W-1:0] L1_END     = ADDR_W'(32'h2000_0000),
   parameter logic [ADDR_W-1:0] L2_START   = ADDR_W'(32'h2000_0000),
   parameter logic [ADDR_W-1:0] L2_END     = ADDR_W'(32'h3000_0000)
) (
   input logic                    clk_i,
   input logic                    rst_i,
   core_data_obi_router_if.slave  mgr,
   core_data_obi_router_if.master sbr
);
   localparam int unsigned CNT_W = $clog2(N_MAX_TRAN + 1);

   typedef enum logic [1:0] {
      TGT_L1  = 2'd0,
      TGT_L2  = 2'd1,
      TGT_ERR = 2'd2
   } tgt_e;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   tgt_e             tgt_q, tgt_d, sel;
   logic             errv_q, errv_d;
   logic [ID_W-1:0]  errid_q, errid_d;
   logic             allow, gnt, hs, rvalid;

   always_comb begin
      sel = TGT_ERR;
      if ((mgr.addr >= L1_START) && (mgr.addr < L1_END)) begin
         sel = TGT_L1;
      end else if ((mgr.addr >= L2_START) && (mgr.addr < L2_END)) begin
         sel = TGT_L2;
      end
   end

   assign sbr.addr  = mgr.addr;
   assign sbr.we    = mgr.we;
   assign sbr.be    = mgr.be;
   assign sbr.wdata = mgr.wdata;
   assign sbr.aid   = mgr.aid;

   // Issue side: no look-ahead on responses, the gate only sees the registered count.
   always_comb begin
      sbr.req = '0;
      gnt     = 1'b0;
      allow   = (cnt_q == '0) || ((cnt_q < CNT_W'(N_MAX_TRAN)) && (tgt_q == sel));
      if (sel == TGT_ERR) begin
         gnt = mgr.req & allow;
      end else begin
         sbr.req[sel[0]] = mgr.req & allow;
         gnt             = sbr.gnt[sel[0]] & mgr.req & allow;
      end
      hs      = mgr.req & gnt;
      mgr.gnt = gnt;
   end

   // Response side: only the current target may answer, and only while something is outstanding.
   always_comb begin
      rvalid    = 1'b0;
      mgr.rdata = '0;
      mgr.rid   = '0;
      mgr.err   = 1'b0;
      if (cnt_q != '0) begin
         rvalid = (tgt_q == TGT_ERR) ? errv_q : sbr.rvalid[tgt_q[0]];
      end
      if (rvalid) begin
         if (tgt_q == TGT_ERR) begin
            mgr.rid = errid_q;
            mgr.err = 1'b1;
         end else if (tgt_q[0]) begin
            mgr.rdata = sbr.rdata[2*DATA_W-1:DATA_W];
            mgr.rid   = sbr.rid[2*ID_W-1:ID_W];
            mgr.err   = sbr.err[1];
         end else begin
            mgr.rdata = sbr.rdata[DATA_W-1:0];
            mgr.rid   = sbr.rid[ID_W-1:0];
            mgr.err   = sbr.err[0];
         end
      end
      mgr.rvalid = rvalid;
   end

   always_comb begin
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      errv_d  = 1'b0;
      errid_d = errid_q;
      if (hs && !rvalid) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!hs && rvalid) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (hs) begin
         tgt_d = sel;
         if (sel == TGT_ERR) begin
            errv_d  = 1'b1;
            errid_d = mgr.aid;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         tgt_q   <= TGT_L1;
         errv_q  <= 1'b0;
         errid_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         errv_q  <= errv_d;
         errid_q <= errid_d;
      end
   end
endmodule
